mips_result_checker: RTL and testbench

- Synthesizable self-check unit for the MIPS core's 16-bit test_value debug output; replaces open-loop waveform inspection in the MIPS test environment.
- Holds a programmable table of expected values and watches test_value for changes. Each change is an event, compared in order against the table.
- Reports pass/fail, mismatch count, first failing index/value, and a no-progress watchdog timeout.
- Width, table depth and timeout are parametrised.

---
 rtl/mips_result_checker.sv | 116 +++++++++++
 tb/tb_mips_result_checker.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_result_checker.sv
// Self-check unit for the MIPS test_value debug bus: every change of the bus is
// an event, compared in order against a programmable table of expected values.
module mips_result_checker #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] test_value,
  input  logic              exp_we,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [ADDR_W:0]   num_exp,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [ADDR_W:0]   mismatch_cnt,
  output logic [ADDR_W-1:0] fail_idx,
  output logic [DATA_W-1:0] fail_value
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  num_q;
  logic [DATA_W-1:0] prev;
  logic [ADDR_W-1:0] idx;
  logic [WD_W-1:0]   wdog;
  logic [DATA_W-1:0] exp_mem [DEPTH];

  logic idle_like, accept_start, evt, mism, last_evt, wd_expire;

  // NOTE: every combinational output is given a default first so no path infers a latch.
  always_comb begin
    idle_like    = (state == S_IDLE) || (state == S_DONE);
    accept_start = start && idle_like;
    evt          = (state == S_RUN) && (test_value != prev);
    mism         = evt && (exp_mem[idx] != test_value);
    last_evt     = evt && ({1'b0, idx} == (num_q - CNT_W'(1)));
    wd_expire    = (state == S_RUN) && !evt && (wdog == WD_MAX);

    state_d = state;
    case (state)
      S_IDLE:  if (accept_start) state_d = S_ARM;
      S_ARM:   state_d = (num_q != '0) ? S_RUN : S_DONE;
      S_RUN:   if (last_evt || wd_expire) state_d = S_DONE;
      S_DONE:  if (accept_start) state_d = S_ARM;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the expected-value table has no reset; its contents are only defined once written.
  always_ff @(posedge clk) begin
    if (exp_we && idle_like) exp_mem[exp_addr] <= exp_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      num_q        <= '0;
      prev         <= '0;
      idx          <= '0;
      wdog         <= '0;
      timeout      <= 1'b0;
      mismatch_cnt <= '0;
      fail_idx     <= '0;
      fail_value   <= '0;
    end else begin
      state <= state_d;

      if (accept_start) begin
        num_q        <= num_exp;
        timeout      <= 1'b0;
        mismatch_cnt <= '0;
        fail_idx     <= '0;
        fail_value   <= '0;
        idx          <= '0;
        wdog         <= '0;
      end

      // The value present while arming is the baseline, not an event.
      if (state == S_ARM || state == S_RUN) prev <= test_value;

      if (evt) begin
        wdog <= '0;
        if (!last_evt) idx <= idx + ADDR_W'(1);
        if (mism) begin
          if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
          if (mismatch_cnt == '0) begin
            fail_idx   <= idx;
            fail_value <= test_value;
          end
        end
      end else if (state == S_RUN) begin
        if (wd_expire) timeout <= 1'b1;
        else           wdog    <= wdog + WD_W'(1);
      end
    end
  end

  always_comb begin
    busy = (state == S_ARM) || (state == S_RUN);
    done = (state == S_DONE);
    pass = done && (mismatch_cnt == '0) && !timeout;
  end

endmodule

// File: tb/tb_mips_result_checker.sv
// Directed bench for mips_result_checker: expected run results are queued when a
// run is launched and a monitor compares them when done rises.
module tb_mips_result_checker;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] test_value;
  logic              exp_we;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic [ADDR_W:0]   num_exp;
  logic              start;
  logic              busy, done, pass, timeout;
  logic [ADDR_W:0]   mismatch_cnt;
  logic [ADDR_W-1:0] fail_idx;
  logic [DATA_W-1:0] fail_value;

  mips_result_checker #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .test_value(test_value),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
    .num_exp(num_exp), .start(start), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .mismatch_cnt(mismatch_cnt),
    .fail_idx(fail_idx), .fail_value(fail_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              pass;
    logic              timeout;
    logic [ADDR_W:0]   mc;
    logic [ADDR_W-1:0] fi;
    logic [DATA_W-1:0] fv;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic done_d = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic p, input logic t, input logic [ADDR_W:0] mc,
                          input logic [ADDR_W-1:0] fi, input logic [DATA_W-1:0] fv);
    exp_t e;
    e.pass = p; e.timeout = t; e.mc = mc; e.fi = fi; e.fv = fv;
    sb.push_back(e);
  endtask

  // Monitor: a rising done is a completed run and consumes one expected result.
  always @(negedge clk) begin
    if (!reset) begin
      done_d = 1'b0;
    end else begin
      if (done && !done_d) begin
        check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("run_pass", 32'(pass), 32'(e.pass));
          check("run_timeout", 32'(timeout), 32'(e.timeout));
          check("run_mismatch_cnt", 32'(mismatch_cnt), 32'(e.mc));
          check("run_fail_idx", 32'(fail_idx), 32'(e.fi));
          check("run_fail_value", 32'(fail_value), 32'(e.fv));
        end
      end
      done_d = done;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_we = 1'b1; exp_addr = a; exp_data = d;
    tick(1);
    exp_we = 1'b0;
  endtask

  task automatic do_start(input logic [ADDR_W:0] n);
    num_exp = n; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic drive(input logic [DATA_W-1:0] v, input int hold);
    test_value = v;
    tick(hold);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick(1);
      n++;
    end
    check(name, 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; test_value = '0; exp_we = 1'b0; exp_addr = '0; exp_data = '0;
    num_exp = '0; start = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_mismatch_cnt", 32'(mismatch_cnt), 32'd0);
    check("rst_fail_idx", 32'(fail_idx), 32'd0);
    check("rst_fail_value", 32'(fail_value), 32'd0);
    reset = 1'b1;
    tick(1);

    // Clean pass with values held several cycles each.
    load(0, 16'h0001); load(1, 16'h0002); load(2, 16'h0003);
    push_exp(1'b1, 1'b0, 0, 0, 0);
    test_value = 16'h0000;
    do_start(3);
    check("arm_busy", 32'(busy), 32'd1);
    drive(16'h0000, 5); drive(16'h0001, 5); drive(16'h0002, 5); drive(16'h0003, 5);
    wait_done("clean_done", 20);
    drive(16'h0009, 2); drive(16'h0003, 2);
    check("after_done_mc", 32'(mismatch_cnt), 32'd0);
    check("after_done_pass", 32'(pass), 32'd1);

    // Two mismatches; the first one is the one recorded.
    push_exp(1'b0, 1'b0, 2, 1, 16'h00FF);
    test_value = 16'h0000;
    do_start(3);
    drive(16'h0000, 2); drive(16'h0001, 2); drive(16'h00FF, 2); drive(16'h0004, 2);
    wait_done("mismatch_done", 20);

    // Zero-length run completes two cycles after start.
    push_exp(1'b1, 1'b0, 0, 0, 0);
    do_start(0);
    check("zero_arm_done", 32'(done), 32'd0);
    tick(1);
    check("zero_done", 32'(done), 32'd1);
    check("zero_pass", 32'(pass), 32'd1);

    // start and exp_we during RUN must be ignored.
    push_exp(1'b1, 1'b0, 0, 0, 0);
    test_value = 16'h0000;
    do_start(3);
    drive(16'h0000, 2); drive(16'h0001, 3);
    start = 1'b1; exp_we = 1'b1; exp_addr = 1; exp_data = 16'h0BAD; num_exp = 1;
    tick(1);
    start = 1'b0; exp_we = 1'b0;
    check("ignored_busy", 32'(busy), 32'd1);
    drive(16'h0002, 3); drive(16'h0003, 3);
    wait_done("ignored_done", 20);

    // Watchdog; the table write in the accepted-start cycle takes effect.
    push_exp(1'b0, 1'b1, 0, 0, 0);
    test_value = 16'h0000;
    num_exp = 2; start = 1'b1; exp_we = 1'b1; exp_addr = 0; exp_data = 16'h00A5;
    tick(1);
    start = 1'b0; exp_we = 1'b0;
    tick(1);
    drive(16'h00A5, 1);
    tick(15);
    check("wd_not_yet", 32'(timeout), 32'd0);
    check("wd_not_done", 32'(done), 32'd0);
    tick(1);
    check("wd_timeout", 32'(timeout), 32'd1);
    check("wd_done", 32'(done), 32'd1);
    check("wd_pass", 32'(pass), 32'd0);
    check("wd_mc", 32'(mismatch_cnt), 32'd0);

    // Reset in the middle of a run after one mismatch.
    load(0, 16'h0001);
    test_value = 16'h0000;
    do_start(3);
    tick(1);
    drive(16'h0077, 1);
    check("pre_rst_mc", 32'(mismatch_cnt), 32'd1);
    check("pre_rst_fail_value", 32'(fail_value), 32'h0077);
    #2 reset = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_mc", 32'(mismatch_cnt), 32'd0);
    reset = 1'b1;
    tick(1);
    load(0, 16'h0001); load(1, 16'h0002); load(2, 16'h0003);
    push_exp(1'b1, 1'b0, 0, 0, 0);
    test_value = 16'h0000;
    do_start(3);
    drive(16'h0000, 2); drive(16'h0001, 2); drive(16'h0002, 2); drive(16'h0003, 2);
    wait_done("post_rst_done", 20);

    // Back-to-back changes, then a failing run, then a re-arm from DONE.
    load(0, 16'h0005); load(1, 16'h0006); load(2, 16'h0007);
    push_exp(1'b1, 1'b0, 0, 0, 0);
    test_value = 16'h0000;
    do_start(3);
    tick(1);
    drive(16'h0005, 1); drive(16'h0006, 1); drive(16'h0007, 1);
    wait_done("b2b_done", 10);
    push_exp(1'b0, 1'b0, 1, 1, 16'h0009);
    test_value = 16'h0000;
    do_start(3);
    tick(1);
    drive(16'h0005, 1); drive(16'h0009, 1); drive(16'h0007, 1);
    wait_done("b2b_fail_done", 10);
    push_exp(1'b1, 1'b0, 0, 0, 0);
    test_value = 16'h0000;
    do_start(3);
    check("rearm_done", 32'(done), 32'd0);
    check("rearm_busy", 32'(busy), 32'd1);
    check("rearm_mc", 32'(mismatch_cnt), 32'd0);
    check("rearm_fail_idx", 32'(fail_idx), 32'd0);
    check("rearm_fail_value", 32'(fail_value), 32'd0);
    tick(1);
    drive(16'h0005, 1); drive(16'h0006, 1); drive(16'h0007, 1);
    wait_done("rearm_run_done", 10);

    tick(3);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
